// File: rtl/ssram_port_arbiter_pkg.sv
// Shared definitions for the SSRAM port arbiter: owner encoding and
// starvation-counter defaults.
package ssram_port_arbiter_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_A    = 2'd1,
      OWN_B0   = 2'd2,
      OWN_B1   = 2'd3
   } owner_t;

   localparam int unsigned DEF_STARVE_LIMIT = 15;
   localparam int unsigned CNT_W            = 8;

endpackage

// File: rtl/ssram_starve_cnt.sv
// Per-port saturating wait counter; flags a B port that has been held off
// for LIMIT consecutive requesting cycles.
module ssram_starve_cnt
   import ssram_port_arbiter_pkg::*;
#(
   parameter int unsigned LIMIT = DEF_STARVE_LIMIT
) (
   input  logic HCLK,
   input  logic HRESETn,
   input  logic req,
   input  logic gnt,
   output logic starve
);

   localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         cnt <= '0;
      end else if (!req || gnt) begin
         cnt <= '0;
      end else if (cnt != LIM) begin
         cnt <= cnt + 8'd1;
      end
   end

   assign starve = (cnt == LIM);

endmodule

// File: rtl/ssram_port_arbiter.sv
// Single-port SSRAM sharing: bridge port A has absolute priority, B0/B1
// share leftover cycles round-robin with registered read-valid return.
module ssram_port_arbiter
   import ssram_port_arbiter_pkg::*;
#(
   parameter int unsigned AW           = 12,
   parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic [AW-1:0] a_addr,
   input  logic          a_en,
   input  logic [3:0]    a_enb,
   input  logic          a_we,
   input  logic [3:0]    a_wb,
   input  logic [31:0]   a_din,
   output logic [31:0]   a_dout,
   input  logic          b0_req,
   input  logic          b0_we,
   input  logic [AW-1:0] b0_addr,
   input  logic [3:0]    b0_be,
   input  logic [31:0]   b0_wdata,
   output logic          b0_gnt,
   output logic          b0_rvalid,
   input  logic          b1_req,
   input  logic          b1_we,
   input  logic [AW-1:0] b1_addr,
   input  logic [3:0]    b1_be,
   input  logic [31:0]   b1_wdata,
   output logic          b1_gnt,
   output logic          b1_rvalid,
   output logic [31:0]   b_rdata,
   output logic [AW-1:0] sram_addr,
   output logic          sram_en,
   output logic [3:0]    sram_enb,
   output logic          sram_we,
   output logic [3:0]    sram_wb,
   output logic [31:0]   sram_din,
   input  logic [31:0]   sram_dout,
   output logic [1:0]    starve
);

   owner_t     owner;
   logic       last_b;
   logic [1:0] rd_pend;

   // last_b: 0 = B0 granted last, 1 = B1 granted last
   always_comb begin
      owner = OWN_NONE;
      if (a_en) begin
         owner = OWN_A;
      end else if (b0_req && b1_req) begin
         owner = last_b ? OWN_B0 : OWN_B1;
      end else if (b0_req) begin
         owner = OWN_B0;
      end else if (b1_req) begin
         owner = OWN_B1;
      end
   end

   always_comb begin
      sram_addr = b0_addr;
      sram_din  = b0_wdata;
      sram_en   = 1'b0;
      sram_enb  = 4'b0000;
      sram_we   = 1'b0;
      sram_wb   = 4'b0000;
      unique case (owner)
         OWN_A: begin
            sram_addr = a_addr;
            sram_din  = a_din;
            sram_en   = 1'b1;
            sram_enb  = a_enb;
            sram_we   = a_we;
            sram_wb   = a_wb;
         end
         OWN_B0: begin
            sram_en   = 1'b1;
            sram_enb  = b0_be;
            sram_we   = b0_we;
            sram_wb   = b0_be & {4{b0_we}};
         end
         OWN_B1: begin
            sram_addr = b1_addr;
            sram_din  = b1_wdata;
            sram_en   = 1'b1;
            sram_enb  = b1_be;
            sram_we   = b1_we;
            sram_wb   = b1_be & {4{b1_we}};
         end
         default: ;
      endcase
   end

   // SRAM muxing follows owner even in reset, but no handshake is issued
   assign b0_gnt = HRESETn && (owner == OWN_B0);
   assign b1_gnt = HRESETn && (owner == OWN_B1);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         last_b  <= 1'b1;
         rd_pend <= '0;
      end else begin
         rd_pend <= {b1_gnt & ~b1_we, b0_gnt & ~b0_we};
         if (b0_gnt) begin
            last_b <= 1'b0;
         end else if (b1_gnt) begin
            last_b <= 1'b1;
         end
      end
   end

   assign b0_rvalid = rd_pend[0];
   assign b1_rvalid = rd_pend[1];
   assign b_rdata   = sram_dout;
   assign a_dout    = sram_dout;

   ssram_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve_b0 (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .req     (b0_req),
      .gnt     (b0_gnt),
      .starve  (starve[0])
   );

   ssram_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve_b1 (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .req     (b1_req),
      .gnt     (b1_gnt),
      .starve  (starve[1])
   );

endmodule

// File: tb/tb_ssram_port_arbiter.sv
// Directed bench for ssram_port_arbiter with a behavioural synchronous SRAM
// attached to the sram_* port.
module tb_ssram_port_arbiter;

   localparam int unsigned AW = 12;

   logic          HCLK;
   logic          HRESETn;
   logic [AW-1:0] a_addr;
   logic          a_en;
   logic [3:0]    a_enb;
   logic          a_we;
   logic [3:0]    a_wb;
   logic [31:0]   a_din;
   logic [31:0]   a_dout;
   logic          b0_req, b0_we, b0_gnt, b0_rvalid;
   logic [AW-1:0] b0_addr;
   logic [3:0]    b0_be;
   logic [31:0]   b0_wdata;
   logic          b1_req, b1_we, b1_gnt, b1_rvalid;
   logic [AW-1:0] b1_addr;
   logic [3:0]    b1_be;
   logic [31:0]   b1_wdata;
   logic [31:0]   b_rdata;
   logic [AW-1:0] sram_addr;
   logic          sram_en, sram_we;
   logic [3:0]    sram_enb, sram_wb;
   logic [31:0]   sram_din, sram_dout;
   logic [1:0]    starve;

   int unsigned total = 0;
   int unsigned bad   = 0;

   ssram_port_arbiter #(.AW(AW), .STARVE_LIMIT(15)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .a_addr    (a_addr),
      .a_en      (a_en),
      .a_enb     (a_enb),
      .a_we      (a_we),
      .a_wb      (a_wb),
      .a_din     (a_din),
      .a_dout    (a_dout),
      .b0_req    (b0_req),
      .b0_we     (b0_we),
      .b0_addr   (b0_addr),
      .b0_be     (b0_be),
      .b0_wdata  (b0_wdata),
      .b0_gnt    (b0_gnt),
      .b0_rvalid (b0_rvalid),
      .b1_req    (b1_req),
      .b1_we     (b1_we),
      .b1_addr   (b1_addr),
      .b1_be     (b1_be),
      .b1_wdata  (b1_wdata),
      .b1_gnt    (b1_gnt),
      .b1_rvalid (b1_rvalid),
      .b_rdata   (b_rdata),
      .sram_addr (sram_addr),
      .sram_en   (sram_en),
      .sram_enb  (sram_enb),
      .sram_we   (sram_we),
      .sram_wb   (sram_wb),
      .sram_din  (sram_din),
      .sram_dout (sram_dout),
      .starve    (starve)
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   logic [31:0] mem [0:(1<<AW)-1];

   always @(posedge HCLK) begin
      if (sram_en) begin
         if (sram_we) begin
            for (int i = 0; i < 4; i++) begin
               if (sram_wb[i]) mem[sram_addr][8*i +: 8] <= sram_din[8*i +: 8];
            end
         end else begin
            sram_dout <= mem[sram_addr];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge HCLK);
      #1;
   endtask

   initial begin
      HRESETn = 1'b0;
      a_addr = '0; a_en = 1'b0; a_enb = '0; a_we = 1'b0; a_wb = '0; a_din = '0;
      b0_req = 1'b0; b0_we = 1'b0; b0_addr = '0; b0_be = '0; b0_wdata = '0;
      b1_req = 1'b0; b1_we = 1'b0; b1_addr = '0; b1_be = '0; b1_wdata = '0;

      // reset state
      cyc();
      check("rst_gnt",    32'({b1_gnt, b0_gnt}), 32'd0);
      check("rst_rvalid", 32'({b1_rvalid, b0_rvalid}), 32'd0);
      check("rst_starve", 32'(starve), 32'd0);
      check("rst_sram_en", 32'(sram_en), 32'd0);
      b0_req = 1'b1;
      #2;
      check("rst_b0_nognt", 32'(b0_gnt), 32'd0);
      check("rst_b0_sram_en", 32'(sram_en), 32'd1);
      b0_req = 1'b0;

      // preload through port A while still in reset
      a_en = 1'b1; a_we = 1'b1; a_wb = 4'hF; a_enb = 4'hF;
      a_addr = 12'h010; a_din = 32'hDEADBEEF;
      #2;
      check("rst_a_we",   32'(sram_we), 32'd1);
      check("rst_a_addr", 32'(sram_addr), 32'h010);
      cyc();
      a_addr = 12'h030; a_din = 32'h11223344;
      cyc();
      a_en = 1'b0; a_we = 1'b0; a_wb = '0; a_enb = '0;
      HRESETn = 1'b1;

      // B0 read, zero-latency grant, rvalid one cycle later
      b0_req = 1'b1; b0_we = 1'b0; b0_addr = 12'h010; b0_be = 4'hF;
      #2;
      check("t1_b0_gnt",  32'(b0_gnt), 32'd1);
      check("t1_b1_gnt",  32'(b1_gnt), 32'd0);
      check("t1_addr",    32'(sram_addr), 32'h010);
      check("t1_en_we",   32'({sram_en, sram_we}), 32'b10);
      cyc();
      b0_req = 1'b0;
      check("t1_rvalid",  32'({b1_rvalid, b0_rvalid}), 32'b01);
      check("t1_rdata",   b_rdata, 32'hDEADBEEF);
      cyc();
      check("t1_rvalid_off", 32'({b1_rvalid, b0_rvalid}), 32'b00);

      // both writing continuously after a fresh reset: B0,B1,B0,B1
      HRESETn = 1'b0;
      cyc();
      HRESETn = 1'b1;
      b0_req = 1'b1; b0_we = 1'b1; b0_addr = 12'h020; b0_be = 4'hF; b0_wdata = 32'hB0B0B0B0;
      b1_req = 1'b1; b1_we = 1'b1; b1_addr = 12'h021; b1_be = 4'hF; b1_wdata = 32'hB1B1B1B1;
      for (int i = 0; i < 4; i++) begin
         #2;
         check("t2_gnt", 32'({b1_gnt, b0_gnt}), (i % 2 == 0) ? 32'b01 : 32'b10);
         check("t2_wb",  32'({sram_we, sram_wb}), 32'h1F);
         cyc();
      end
      b0_req = 1'b0; b1_req = 1'b0; b0_we = 1'b0; b1_we = 1'b0;
      check("t2_no_rvalid", 32'({b1_rvalid, b0_rvalid}), 32'b00);
      cyc();

      // A busy 20 cycles while B1 waits
      a_en = 1'b1; a_we = 1'b0; a_enb = 4'hF; a_addr = 12'h010;
      b1_req = 1'b1; b1_we = 1'b0; b1_addr = 12'h021; b1_be = 4'hF;
      for (int k = 1; k <= 20; k++) begin
         #2;
         check("t3_b1_gnt", 32'(b1_gnt), 32'd0);
         check("t3_addr",   32'(sram_addr), 32'h010);
         check("t3_starve", 32'(starve), (k >= 16) ? 32'b10 : 32'b00);
         if (k >= 2) check("t3_a_dout", a_dout, 32'hDEADBEEF);
         cyc();
      end
      a_en = 1'b0;
      #2;
      check("t3_b1_gnt_late", 32'(b1_gnt), 32'd1);
      check("t3_starve_held", 32'(starve), 32'b10);
      cyc();
      b1_req = 1'b0;
      check("t3_rvalid",      32'({b1_rvalid, b0_rvalid}), 32'b10);
      check("t3_rdata",       b_rdata, 32'hB1B1B1B1);
      check("t3_starve_clr",  32'(starve), 32'b00);

      // B1 single-byte write
      b1_req = 1'b1; b1_we = 1'b1; b1_addr = 12'h030; b1_be = 4'b0100; b1_wdata = 32'h00AB0000;
      #2;
      check("t4_gnt", 32'(b1_gnt), 32'd1);
      check("t4_wb",  32'(sram_wb), 32'b0100);
      check("t4_enb", 32'(sram_enb), 32'b0100);
      check("t4_we",  32'(sram_we), 32'd1);
      check("t4_din", sram_din, 32'h00AB0000);
      cyc();
      b1_req = 1'b0; b1_we = 1'b0;
      a_en = 1'b1; a_we = 1'b0; a_addr = 12'h030; a_enb = 4'hF;
      cyc();
      a_en = 1'b0;
      check("t4_merge", a_dout, 32'h11AB3344);

      // A write collides with B0 read of the same word
      a_en = 1'b1; a_we = 1'b1; a_wb = 4'hF; a_enb = 4'hF; a_addr = 12'h040; a_din = 32'hCAFEF00D;
      b0_req = 1'b1; b0_we = 1'b0; b0_addr = 12'h040; b0_be = 4'hF;
      #2;
      check("t5_b0_nognt", 32'(b0_gnt), 32'd0);
      check("t5_addr",     32'(sram_addr), 32'h040);
      check("t5_we_wb",    32'({sram_we, sram_wb}), 32'h1F);
      check("t5_din",      sram_din, 32'hCAFEF00D);
      cyc();
      a_en = 1'b0; a_we = 1'b0; a_wb = '0;
      #2;
      check("t5_b0_gnt",   32'(b0_gnt), 32'd1);
      check("t5_rd_we",    32'(sram_we), 32'd0);
      cyc();
      b0_req = 1'b0;
      check("t5_rvalid",   32'({b1_rvalid, b0_rvalid}), 32'b01);
      check("t5_rdata",    b_rdata, 32'hCAFEF00D);

      // reset right after a B0 read grant drops the read
      b0_req = 1'b1; b0_we = 1'b0; b0_addr = 12'h010;
      #2;
      check("t6_gnt", 32'(b0_gnt), 32'd1);
      cyc();
      HRESETn = 1'b0;
      b0_req = 1'b0;
      #1;
      check("t6_rvalid_rst", 32'({b1_rvalid, b0_rvalid}), 32'b00);
      check("t6_starve_rst", 32'(starve), 32'b00);
      cyc();
      HRESETn = 1'b1;
      cyc();
      check("t6_rvalid_rel", 32'({b1_rvalid, b0_rvalid}), 32'b00);

      // alternating back-to-back reads, B0 favoured after reset
      b0_req = 1'b1; b0_we = 1'b0; b0_addr = 12'h020;
      b1_req = 1'b1; b1_we = 1'b0; b1_addr = 12'h021;
      #2;
      check("t7_gnt0", 32'({b1_gnt, b0_gnt}), 32'b01);
      cyc();
      #1;
      check("t7_gnt1",    32'({b1_gnt, b0_gnt}), 32'b10);
      check("t7_rvalid0", 32'({b1_rvalid, b0_rvalid}), 32'b01);
      check("t7_rdata0",  b_rdata, 32'hB0B0B0B0);
      cyc();
      b0_req = 1'b0; b1_req = 1'b0;
      check("t7_rvalid1", 32'({b1_rvalid, b0_rvalid}), 32'b10);
      check("t7_rdata1",  b_rdata, 32'hB1B1B1B1);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
